// File: rtl/addsub_accum_mc_if.sv
// Request/result bundle for the multi-channel add/sub accumulator.
// master drives operations and sticky clears; slave is the accumulator.
interface addsub_accum_mc_if #(
    parameter int N  = 8,
    parameter int CH = 4
);
    localparam int CW = $clog2(CH);

    logic          in_valid;
    logic [CW-1:0] in_ch;
    logic [1:0]    in_op;
    logic [N-1:0]  in_data;
    logic          signed_mode;
    logic          sat_en;
    logic [CH-1:0] sticky_clr;

    logic          out_valid;
    logic [CW-1:0] out_ch;
    logic [N-1:0]  out_acc;
    logic          out_carry;
    logic          out_ovf;
    logic [CH-1:0] ovf_sticky;

    modport master (
        output in_valid, in_ch, in_op, in_data, signed_mode, sat_en, sticky_clr,
        input  out_valid, out_ch, out_acc, out_carry, out_ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, in_ch, in_op, in_data, signed_mode, sat_en, sticky_clr,
        output out_valid, out_ch, out_acc, out_carry, out_ovf, ovf_sticky
    );
endinterface

// File: rtl/addsub_accum_mc.sv
// Multi-channel add/sub accumulator: stage 1 registers the request, stage 2 reads,
// computes, writes back the channel accumulator and registers the result outputs.
module addsub_accum_mc #(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input  logic             clk,
    input  logic             aclr,
    addsub_accum_mc_if.slave bus
);
    localparam int          CW     = $clog2(CH);
    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);
    localparam logic [N-1:0] ONES  = '1;
    localparam logic [N-1:0] SMAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN  = {1'b1, {(N-1){1'b0}}};

    logic          s1_valid_reg;
    logic [CW-1:0] s1_ch_reg;
    logic [1:0]    s1_op_reg;
    logic [N-1:0]  s1_data_reg;
    logic          s1_signed_reg;
    logic          s1_sat_reg;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s1_valid_reg  <= 1'b0;
            s1_ch_reg     <= '0;
            s1_op_reg     <= '0;
            s1_data_reg   <= '0;
            s1_signed_reg <= 1'b0;
            s1_sat_reg    <= 1'b0;
        end else begin
            // Requests for channels that do not exist die here.
            s1_valid_reg  <= bus.in_valid && ({1'b0, bus.in_ch} < CH_LIM);
            s1_ch_reg     <= bus.in_ch;
            s1_op_reg     <= bus.in_op;
            s1_data_reg   <= bus.in_data;
            s1_signed_reg <= bus.signed_mode;
            s1_sat_reg    <= bus.sat_en;
        end
    end

    logic [N-1:0]  acc_all [CH];
    logic [CH-1:0] sticky_all;
    logic [N-1:0]  opa;
    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [N-1:0]  res_next;
    logic          carry_next;
    logic          ovf_next;

    always_comb begin
        opa        = acc_all[s1_ch_reg];
        sum        = {1'b0, opa} + {1'b0, s1_data_reg};
        diff       = {1'b0, opa} - {1'b0, s1_data_reg};
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        case (s1_op_reg)
            2'b00: begin
                res_next   = sum[N-1:0];
                carry_next = sum[N];
                ovf_next   = s1_signed_reg
                           ? ((opa[N-1] == s1_data_reg[N-1]) && (sum[N-1] != opa[N-1]))
                           : sum[N];
            end
            2'b01: begin
                res_next   = diff[N-1:0];
                carry_next = diff[N];
                ovf_next   = s1_signed_reg
                           ? ((opa[N-1] != s1_data_reg[N-1]) && (diff[N-1] != opa[N-1]))
                           : diff[N];
            end
            2'b10:   res_next = s1_data_reg;
            default: res_next = '0;
        endcase
        // Signed overflow always runs away from A's sign, so A picks the rail.
        if (s1_sat_reg && ovf_next) begin
            if (s1_signed_reg) res_next = opa[N-1] ? SMIN : SMAX;
            else               res_next = (s1_op_reg == 2'b00) ? ONES : '0;
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [N-1:0] acc_reg;
            logic         sticky_reg;
            logic         hit;

            assign hit = s1_valid_reg && (s1_ch_reg == CW'(gi));

            always_ff @(posedge clk or posedge aclr) begin
                if (aclr) begin
                    acc_reg    <= '0;
                    sticky_reg <= 1'b0;
                end else begin
                    if (hit) acc_reg <= res_next;
                    if (hit && ovf_next)          sticky_reg <= 1'b1;
                    else if (bus.sticky_clr[gi])  sticky_reg <= 1'b0;
                end
            end

            assign acc_all[gi]    = acc_reg;
            assign sticky_all[gi] = sticky_reg;
        end
    endgenerate

    logic          out_valid_reg;
    logic [CW-1:0] out_ch_reg;
    logic [N-1:0]  out_acc_reg;
    logic          out_carry_reg;
    logic          out_ovf_reg;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_acc_reg   <= '0;
            out_carry_reg <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_ch_reg    <= s1_ch_reg;
                out_acc_reg   <= res_next;
                out_carry_reg <= carry_next;
                out_ovf_reg   <= ovf_next;
            end
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_ch     = out_ch_reg;
    assign bus.out_acc    = out_acc_reg;
    assign bus.out_carry  = out_carry_reg;
    assign bus.out_ovf    = out_ovf_reg;
    assign bus.ovf_sticky = sticky_all;
endmodule

// File: tb/tb_addsub_accum_mc.sv
// Bench for addsub_accum_mc: directed scenarios with fixed expectations, then
// randomized traffic checked against an integer-arithmetic reference model.
module tb_addsub_accum_mc;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int CW = 2;

    typedef struct packed {
        int            cyc;
        logic [CW-1:0] ch;
        logic [N-1:0]  acc;
        logic          carry;
        logic          ovf;
    } res_t;

    logic clk  = 1'b0;
    logic aclr = 1'b1;
    int   cyc  = 0;
    int   checks   = 0;
    int   failures = 0;
    res_t got_q[$];
    res_t exp_q[$];
    int   macc[CH];
    bit [CH-1:0] msticky;

    addsub_accum_mc_if #(.N(N), .CH(CH)) bus ();
    addsub_accum_mc #(.N(N), .CH(CH)) dut (.clk(clk), .aclr(aclr), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1)
            got_q.push_back(res_t'{cyc, bus.out_ch, bus.out_acc, bus.out_carry, bus.out_ovf});
    end

    function automatic res_t mk(int c, int ch, int acc, bit carry, bit ovf);
        res_t r;
        r.cyc = c; r.ch = CW'(ch); r.acc = N'(acc); r.carry = carry; r.ovf = ovf;
        return r;
    endfunction

    // Reference: true integer results, then fold into N bits and judge the range.
    function automatic res_t model(int ch, int op, int b, bit sm, bit sat);
        res_t r;
        int lim  = 1 << N;
        int hmax = (1 << (N - 1)) - 1;
        int hmin = -(1 << (N - 1));
        int a = macc[ch];
        int full, sa, sb, s, res;
        bit c = 1'b0;
        bit o = 1'b0;
        if (op == 2)      res = b;
        else if (op == 3) res = 0;
        else begin
            full = (op == 0) ? a + b : a - b;
            c    = (full < 0) || (full >= lim);
            res  = full & (lim - 1);
            sa   = (a > hmax) ? a - lim : a;
            sb   = (b > hmax) ? b - lim : b;
            s    = (op == 0) ? sa + sb : sa - sb;
            o    = sm ? ((s > hmax) || (s < hmin)) : c;
            if (sat && o) begin
                if (sm) res = (s > hmax) ? hmax : hmin + lim;
                else    res = (op == 0) ? lim - 1 : 0;
            end
        end
        macc[ch] = res;
        if (o) msticky[ch] = 1'b1;
        return mk(0, ch, res, c, o);
    endfunction

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(int ch, int op, int data, bit sm, bit sat);
        res_t r;
        bus.in_valid    = 1'b1;
        bus.in_ch       = CW'(ch);
        bus.in_op       = 2'(op);
        bus.in_data     = N'(data);
        bus.signed_mode = sm;
        bus.sat_en      = sat;
        r = model(ch, op, data, sm, sat);
        r.cyc = cyc + 2;
        exp_q.push_back(r);
        idle(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b required=0", bus.out_valid);
        end
        checks++;
        if ({bus.out_ch, bus.out_acc, bus.out_carry, bus.out_ovf} !== '0) begin
            failures++; $display("FAIL reset_outputs got ch=%0d acc=%h c=%b o=%b required all 0",
                                 bus.out_ch, bus.out_acc, bus.out_carry, bus.out_ovf);
        end
        checks++;
        if (bus.ovf_sticky !== '0) begin
            failures++; $display("FAIL reset_sticky got=%b required=0000", bus.ovf_sticky);
        end
        idle(2);
        aclr = 1'b0;
        idle(3);
        checks++;
        if (got_q.size() != 0) begin
            failures++; $display("FAIL reset_spurious got=%0d results required=0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_accumulate();
        res_t e[$];
        res_t r;
        int t0 = cyc;
        issue(0, 0, 'h10, 0, 0);
        issue(0, 0, 'h10, 0, 0);
        idle(3);
        e.push_back(mk(t0 + 2, 0, 'h10, 0, 0));
        e.push_back(mk(t0 + 3, 0, 'h20, 0, 0));
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== e[i]) begin
                failures++;
                $display("FAIL accumulate[%0d] got cyc=%0d ch=%0d acc=%h c=%b o=%b required cyc=%0d ch=%0d acc=%h c=%b o=%b",
                         i, r.cyc, r.ch, r.acc, r.carry, r.ovf, e[i].cyc, e[i].ch, e[i].acc, e[i].carry, e[i].ovf);
            end
        end
    endtask

    task automatic test_unsigned_sat();
        res_t e[$];
        res_t r;
        int t0 = cyc;
        issue(1, 2, 'hF0, 0, 0);
        issue(1, 0, 'h20, 0, 0);
        issue(1, 2, 'hF0, 0, 1);
        issue(1, 0, 'h20, 0, 1);
        issue(1, 2, 'h10, 0, 1);
        issue(1, 1, 'h20, 0, 1);
        idle(3);
        e.push_back(mk(t0 + 2, 1, 'hF0, 0, 0));
        e.push_back(mk(t0 + 3, 1, 'h10, 1, 1));
        e.push_back(mk(t0 + 4, 1, 'hF0, 0, 0));
        e.push_back(mk(t0 + 5, 1, 'hFF, 1, 1));
        e.push_back(mk(t0 + 6, 1, 'h10, 0, 0));
        e.push_back(mk(t0 + 7, 1, 'h00, 1, 1));
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== e[i]) begin
                failures++;
                $display("FAIL unsigned_sat[%0d] got cyc=%0d ch=%0d acc=%h c=%b o=%b required cyc=%0d ch=%0d acc=%h c=%b o=%b",
                         i, r.cyc, r.ch, r.acc, r.carry, r.ovf, e[i].cyc, e[i].ch, e[i].acc, e[i].carry, e[i].ovf);
            end
        end
    endtask

    task automatic test_signed_sat();
        res_t e[$];
        res_t r;
        int t0 = cyc;
        issue(2, 2, 'h70, 1, 1);
        issue(2, 0, 'h20, 1, 1);
        issue(2, 2, 'h80, 1, 1);
        issue(2, 1, 'h01, 1, 1);
        idle(3);
        e.push_back(mk(t0 + 2, 2, 'h70, 0, 0));
        e.push_back(mk(t0 + 3, 2, 'h7F, 0, 1));
        e.push_back(mk(t0 + 4, 2, 'h80, 0, 0));
        e.push_back(mk(t0 + 5, 2, 'h80, 0, 1));
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== e[i]) begin
                failures++;
                $display("FAIL signed_sat[%0d] got cyc=%0d ch=%0d acc=%h c=%b o=%b required cyc=%0d ch=%0d acc=%h c=%b o=%b",
                         i, r.cyc, r.ch, r.acc, r.carry, r.ovf, e[i].cyc, e[i].ch, e[i].acc, e[i].carry, e[i].ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e[$];
        res_t r;
        int t0 = cyc;
        issue(0, 3, 'h00, 0, 0);
        issue(1, 3, 'h00, 0, 0);
        issue(0, 0, 'h01, 0, 0);
        issue(1, 0, 'h02, 0, 0);
        issue(0, 0, 'h01, 0, 0);
        idle(3);
        e.push_back(mk(t0 + 2, 0, 'h00, 0, 0));
        e.push_back(mk(t0 + 3, 1, 'h00, 0, 0));
        e.push_back(mk(t0 + 4, 0, 'h01, 0, 0));
        e.push_back(mk(t0 + 5, 1, 'h02, 0, 0));
        e.push_back(mk(t0 + 6, 0, 'h02, 0, 0));
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== e[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d] got cyc=%0d ch=%0d acc=%h c=%b o=%b required cyc=%0d ch=%0d acc=%h c=%b o=%b",
                         i, r.cyc, r.ch, r.acc, r.carry, r.ovf, e[i].cyc, e[i].ch, e[i].acc, e[i].carry, e[i].ovf);
            end
        end
    endtask

    task automatic test_sticky();
        res_t e[$];
        res_t r;
        int t0;
        bus.sticky_clr = '1;
        idle(1);
        bus.sticky_clr = '0;
        checks++;
        if (bus.ovf_sticky !== 4'b0000) begin
            failures++; $display("FAIL sticky_clear_all got=%b required=0000", bus.ovf_sticky);
        end
        t0 = cyc;
        issue(1, 2, 'hFF, 0, 0);
        issue(1, 0, 'h01, 0, 0);
        issue(3, 2, 'hFF, 0, 0);
        issue(3, 0, 'h01, 0, 0);
        // The ch3 overflow is in its writeback cycle now; clearing must lose to setting.
        bus.sticky_clr = 4'b1000;
        idle(1);
        checks++;
        if (bus.ovf_sticky !== 4'b1010) begin
            failures++; $display("FAIL sticky_set_wins got=%b required=1010", bus.ovf_sticky);
        end
        idle(1);
        checks++;
        if (bus.ovf_sticky !== 4'b0010) begin
            failures++; $display("FAIL sticky_clr got=%b required=0010", bus.ovf_sticky);
        end
        bus.sticky_clr = '0;
        idle(2);
        e.push_back(mk(t0 + 2, 1, 'hFF, 0, 0));
        e.push_back(mk(t0 + 3, 1, 'h00, 1, 1));
        e.push_back(mk(t0 + 4, 3, 'hFF, 0, 0));
        e.push_back(mk(t0 + 5, 3, 'h00, 1, 1));
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== e[i]) begin
                failures++;
                $display("FAIL sticky_results[%0d] got cyc=%0d ch=%0d acc=%h c=%b o=%b required cyc=%0d ch=%0d acc=%h c=%b o=%b",
                         i, r.cyc, r.ch, r.acc, r.carry, r.ovf, e[i].cyc, e[i].ch, e[i].acc, e[i].carry, e[i].ovf);
            end
        end
    endtask

    task automatic test_aclr_midflight();
        res_t r;
        int t0 = cyc;
        for (int k = 0; k < CH; k++) issue(k, 2, 'h11 * (k + 1), 0, 0);
        idle(3);
        for (int k = 0; k < CH; k++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== mk(t0 + 2 + k, k, 'h11 * (k + 1), 0, 0)) begin
                failures++;
                $display("FAIL preload[%0d] got cyc=%0d ch=%0d acc=%h required cyc=%0d ch=%0d acc=%h",
                         k, r.cyc, r.ch, r.acc, t0 + 2 + k, k, 'h11 * (k + 1));
            end
        end
        issue(0, 0, 'h05, 0, 0);
        bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_op = 2'b00; bus.in_data = 8'h05;
        aclr = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_ch, bus.out_acc, bus.out_carry, bus.out_ovf, bus.ovf_sticky} !== '0) begin
            failures++;
            $display("FAIL aclr_async got v=%b ch=%0d acc=%h c=%b o=%b sticky=%b required all 0",
                     bus.out_valid, bus.out_ch, bus.out_acc, bus.out_carry, bus.out_ovf, bus.ovf_sticky);
        end
        idle(1);
        aclr = 1'b0;
        bus.in_valid = 1'b0;
        idle(3);
        checks++;
        if (got_q.size() != 0) begin
            failures++; $display("FAIL aclr_inflight got=%0d results required=0", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
        foreach (macc[k]) macc[k] = 0;
        msticky = '0;
        t0 = cyc;
        for (int k = 0; k < CH; k++) issue(k, 0, 'h00, 0, 0);
        idle(3);
        for (int k = 0; k < CH; k++) begin
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== mk(t0 + 2 + k, k, 0, 0, 0)) begin
                failures++;
                $display("FAIL aclr_readback[%0d] got cyc=%0d ch=%0d acc=%h required cyc=%0d ch=%0d acc=00",
                         k, r.cyc, r.ch, r.acc, t0 + 2 + k, k);
            end
        end
    endtask

    task automatic test_random();
        res_t r;
        res_t e;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 400; i++) begin
            int opsel = int'($urandom_range(0, 9));
            int op    = (opsel < 4) ? 0 : (opsel < 8) ? 1 : opsel - 6;
            if ($urandom_range(0, 3) != 0) begin
                issue(int'($urandom_range(0, CH - 1)), op, int'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                bus.in_valid = 1'b0;
                bus.in_ch    = 2'($urandom_range(0, 3));
                bus.in_op    = 2'($urandom_range(0, 3));
                bus.in_data  = 8'($urandom_range(0, 255));
                idle(1);
            end
        end
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            r = '0;
            if (got_q.size() > 0) r = got_q.pop_front();
            if (r !== e) begin
                failures++;
                $display("FAIL random got cyc=%0d ch=%0d acc=%h c=%b o=%b required cyc=%0d ch=%0d acc=%h c=%b o=%b",
                         r.cyc, r.ch, r.acc, r.carry, r.ovf, e.cyc, e.ch, e.acc, e.carry, e.ovf);
            end
        end
        checks++;
        if (got_q.size() != 0) begin
            failures++; $display("FAIL random_extra got=%0d surplus results required=0", got_q.size());
        end
        checks++;
        if (bus.ovf_sticky !== msticky) begin
            failures++; $display("FAIL random_sticky got=%b required=%b", bus.ovf_sticky, msticky);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_ch       = '0;
        bus.in_op       = '0;
        bus.in_data     = '0;
        bus.signed_mode = 1'b0;
        bus.sat_en      = 1'b0;
        bus.sticky_clr  = '0;
        foreach (macc[k]) macc[k] = 0;
        msticky = '0;
        test_reset();
        test_accumulate();
        test_unsigned_sat();
        test_signed_sat();
        test_back_to_back();
        test_sticky();
        test_aclr_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete required finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
